branch_resolve_unit: RTL
========================

# branch_resolve_unit

Parametrised, pipelined branch resolution unit for the RISC-V pipeline EX stage. It evaluates all six RV32I/RV64I conditional-branch conditions (signed and unsigned), computes the branch target, and compares the outcome against the front-end prediction to raise a redirect. Results are registered through a configurable number of stages behind a valid/ready handshake with flush support. It replaces the purely combinational equal/less-than comparator in the execute path.

## Interface
- XLEN, 32, operand, PC and immediate width (32 or 64)
- STAGES, 1, register stages from input to result, legal range 1..3
- CNT_W, 32, width of the statistics counters

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  input branch valid
- ready_o  out  1  unit accepts input this cycle
- funct3_i  in  3  branch condition encoding
- rs1_i  in  XLEN  operand A
- rs2_i  in  XLEN  operand B
- pc_i  in  XLEN  branch instruction PC
- imm_i  in  XLEN  sign-extended B-type immediate
- pred_taken_i  in  1  front-end prediction
- flush_i  in  1  kill all in-flight entries
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- taken_o  out  1  resolved direction
- target_o  out  XLEN  pc_i + imm_i
- redirect_o  out  1  misprediction, fetch must redirect
- redirect_pc_o  out  XLEN  taken ? target : pc_i + 4
- illegal_o  out  1  funct3 is 010 or 011
- br_count_o  out  CNT_W  resolved-branch count
- mispred_count_o  out  CNT_W  misprediction count

## Operation
- Conditions: 000 BEQ (A==B), 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU. Signed compare treats bit XLEN-1 as sign.
- funct3 010/011: illegal_o=1, taken_o=0, redirect_o=0, redirect_pc_o=pc_i+4.
- Arithmetic: target and pc+4 wrap modulo 2^XLEN; no overflow flag.
- Compare, target and redirect are computed combinationally from inputs and captured in stage 1; stages 2..STAGES only delay the stage-1 payload and valid bit.
- redirect_o = valid_o & ~illegal_o & (taken_o != pred_taken_o) where pred_taken is carried through the pipe.
- Stall: stall = valid_o & ~ready_i. While stalled every stage holds; ready_o = ~stall. Bubbles are not compressed.
- Input accepted when valid_i & ready_o; output consumed when valid_o & ready_i.
- flush_i: all stage valid bits clear on the next edge, including an entry accepted in the same cycle; flush overrides stall. Payload registers need not be cleared.

## Timing
- Latency: accepted input appears on outputs exactly STAGES cycles later when unstalled.
- Throughput: one branch per cycle.
- Reset: valid_o, taken_o, redirect_o, illegal_o = 0; target_o, redirect_pc_o = 0; counters = 0; ready_o = 1 after reset (no valid entries).
- Reset mid-operation drops all in-flight entries asynchronously.
- redirect_o is a registered output; asserted only while valid_o is high.

## Configuration
- BRANCH_STATS_EN defined: br_count_o increments on each output handshake with illegal_o=0; mispred_count_o increments on handshakes with redirect_o=1; both saturate at all-ones; flushed entries are never counted.
- Undefined: counter logic absent; br_count_o and mispred_count_o tied to 0; ports retained for a stable interface.

## Structure
- Shared package riscv_branch_pkg: funct3 enum (BEQ, BNE, BLT, BGE, BLTU, BGEU), pipeline payload struct (taken, illegal, pred_taken, target, redirect_pc), constant PC_INC = 4.
- One sub-module branch_cmp_core: combinational XLEN-wide condition evaluator (funct3, A, B → taken, illegal); the top holds the pipe, handshake, flush and counters.

## Test plan
- STAGES=1, BLT, A=0xFFFFFFFF, B=1, pred=0 → cycle+1: taken_o=1, redirect_o=1, redirect_pc_o=pc+imm; same operands BLTU → taken_o=0, redirect_o=0.
- BEQ A=B=0x1234, pc=0xFFFFFFFC, imm=8, pred=1 → taken_o=1, target_o=0x00000004 (wrap), redirect_o=0.
- STAGES=3, back-to-back 4 branches, ready_i low 2 cycles at output → results in order, none lost or duplicated, ready_o low exactly while stalled.
- flush_i asserted with 2 entries in flight and valid_i high → valid_o stays 0 for STAGES cycles after flush.
- funct3=010 → illegal_o=1, taken_o=0, redirect_o=0; with BRANCH_STATS_EN, br_count_o unchanged.
- BRANCH_STATS_EN, CNT_W=4, 17 mispredicted branches → mispred_count_o=0xF (saturated); rst_i mid-stream → all counters and valid_o 0 immediately.

Source files
------------

// File: rtl/riscv_branch_pkg.sv
// Shared branch-resolution types: funct3 encodings, pipeline payload, PC increment.
// Address fields are sized for the widest XLEN; narrower builds use the low bits.
// No storage or handshake in this file.
package riscv_branch_pkg;

    localparam int XLEN_MAX = 64;
    localparam int PC_INC   = 4;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_funct3_e;

    typedef struct packed {
        logic                taken;
        logic                illegal;
        logic                pred_taken;
        logic [XLEN_MAX-1:0] target;
        logic [XLEN_MAX-1:0] redirect_pc;
    } br_payload_t;

endpackage

// File: rtl/branch_cmp_core.sv
// Conditional-branch evaluator for the six RV32I/RV64I compare encodings.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers and stalls the result.
module branch_cmp_core #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            taken_o,
    output logic            illegal_o
);
    import riscv_branch_pkg::*;

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (a_i == b_i);
    assign lt_s = ($signed(a_i) < $signed(b_i));
    assign lt_u = (a_i < b_i);

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (br_funct3_e'(funct3_i))
            BEQ:     taken_o = eq;
            BNE:     taken_o = ~eq;
            BLT:     taken_o = lt_s;
            BGE:     taken_o = ~lt_s;
            BLTU:    taken_o = lt_u;
            BGEU:    taken_o = ~lt_u;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: direction, target, redirect vs prediction; optional stats (BRANCH_STATS_EN).
// Latency: STAGES cycles from accepted input to valid_o when unstalled.
// Backpressure: valid_o & ~ready_i freezes every stage and drops ready_o; flush_i overrides.
module branch_resolve_unit #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic             pred_taken_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             taken_o,
    output logic [XLEN-1:0]  target_o,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] br_count_o,
    output logic [CNT_W-1:0] mispred_count_o
);
    import riscv_branch_pkg::*;

    localparam int LAST = STAGES - 1;

    logic            cmp_taken;
    logic            cmp_illegal;
    logic [XLEN-1:0] target_calc;
    logic [XLEN-1:0] seq_pc;
    br_payload_t     stage_in;

    logic [STAGES-1:0] valid_q, valid_d;
    br_payload_t       pipe_q [STAGES];
    br_payload_t       pipe_d [STAGES];
    logic              stall;
    logic              unused_payload;

    branch_cmp_core #(.XLEN(XLEN)) u_cmp (
        .funct3_i  (funct3_i),
        .a_i       (rs1_i),
        .b_i       (rs2_i),
        .taken_o   (cmp_taken),
        .illegal_o (cmp_illegal)
    );

    // Both sums wrap naturally at XLEN bits.
    assign target_calc = pc_i + imm_i;
    assign seq_pc      = pc_i + XLEN'(PC_INC);

    always_comb begin
        stage_in                        = '0;
        stage_in.taken                  = cmp_taken;
        stage_in.illegal                = cmp_illegal;
        stage_in.pred_taken             = pred_taken_i;
        stage_in.target[XLEN-1:0]       = target_calc;
        stage_in.redirect_pc[XLEN-1:0]  = cmp_taken ? target_calc : seq_pc;
    end

    assign stall   = valid_q[LAST] & ~ready_i;
    assign ready_o = ~stall;

    always_comb begin
        valid_d = valid_q;
        pipe_d  = pipe_q;
        if (!stall) begin
            valid_d[0] = valid_i;
            pipe_d[0]  = stage_in;
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                pipe_d[i]  = pipe_q[i-1];
            end
        end
        // Flush wins over both stall and a same-cycle accept.
        if (flush_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            pipe_q  <= pipe_d;
        end
    end

    assign valid_o       = valid_q[LAST];
    assign taken_o       = pipe_q[LAST].taken;
    assign illegal_o     = pipe_q[LAST].illegal;
    assign target_o      = pipe_q[LAST].target[XLEN-1:0];
    assign redirect_pc_o = pipe_q[LAST].redirect_pc[XLEN-1:0];
    assign redirect_o    = valid_o & ~pipe_q[LAST].illegal
                         & (pipe_q[LAST].taken ^ pipe_q[LAST].pred_taken);

    // Upper address bits above XLEN are always zero and intentionally dropped.
    assign unused_payload = ^pipe_q[LAST];

`ifdef BRANCH_STATS_EN
    logic             fire;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    assign fire = valid_o & ready_i & ~flush_i;

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (fire && !illegal_o && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (fire && redirect_o && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign br_count_o      = br_cnt_q;
    assign mispred_count_o = mis_cnt_q;
`else
    assign br_count_o      = '0;
    assign mispred_count_o = '0;
`endif

endmodule
